// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared FSM encoding, port ids and counter widths for the data-memory arbiter
package dmem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;
    localparam int LAT_W    = 3;
    localparam int STREAK_W = 4;
endpackage

// File: rtl/dmem_arb_prio.sv
// dmem_arb_prio: fixed CPU priority with a streak counter that forces the DMA port after STARVE_LIMIT wins
module dmem_arb_prio
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic m0_req,
    input  logic m1_req,
    input  logic grant,
    output logic winner
);
    logic [STREAK_W-1:0] streak;
    logic                at_limit;
    assign at_limit = streak == STREAK_W'(STARVE_LIMIT);
    assign winner   = m1_req && (!m0_req || at_limit) ? PORT_DMA : PORT_CPU;
    always_ff @(posedge clk) begin
        if (reset)
            streak <= '0;
        else if (grant)
            streak <= (winner == PORT_DMA || !m1_req) ? '0 : at_limit ? streak : streak + 1'b1;
    end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the CPU MEM stage and a DMA engine
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_stall,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_stall,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        grant_id
);
    state_t           state, state_nx;
    logic [LAT_W-1:0] cnt;
    logic             id;
    logic             grant;
    logic             winner;
    logic             last_beat;
    assign grant     = state == IDLE && (m0_req || m1_req);
    assign last_beat = state == WAIT && cnt == LAT_W'(1);
    dmem_arb_prio #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .clk    (clk),
        .reset  (reset),
        .m0_req (m0_req),
        .m1_req (m1_req),
        .grant  (grant),
        .winner (winner)
    );
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state == IDLE   ? (grant ? ACCESS : IDLE) :
                   state == ACCESS ? (mem_we ? DONE : WAIT) :
                   state == WAIT   ? (last_beat ? DONE : WAIT) : IDLE;
    end
    always_comb begin
        mem_en   = state == ACCESS;
        busy     = state != IDLE;
        grant_id = busy ? id : PORT_CPU;
        m0_ack   = state == DONE && id == PORT_CPU;
        m1_ack   = state == DONE && id == PORT_DMA;
        m0_stall = m0_req && !m0_ack;
        m1_stall = m1_req && !m1_ack;
    end
    // The transaction latch doubles as the RAM bus, so it holds outside ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            id        <= PORT_CPU;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cnt       <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
        end else begin
            if (grant) begin
                id        <= winner;
                mem_we    <= winner ? m1_we : m0_we;
                mem_addr  <= winner ? m1_addr : m0_addr;
                mem_wdata <= winner ? m1_wdata : m0_wdata;
            end
            if (state == ACCESS)
                cnt <= RD_LATENCY[LAT_W-1:0];
            else if (state == WAIT)
                cnt <= cnt - 1'b1;
            if (last_beat && id == PORT_CPU)
                m0_rdata <= mem_rdata;
            if (last_beat && id == PORT_DMA)
                m1_rdata <= mem_rdata;
        end
    end
endmodule
